cmd_decode_queue: RTL and testbench
===================================

// Module: cmd_decode_queue
// PURPOSE
//  Buffered, parametrised command-word decoder between instruction fetch and the execute/register-access stages.
//  Accepts raw command words on a valid/ready stream and queues them in a DEPTH-entry FIFO.
//  Splits the FIFO head into register-number, pointer, flag, condition and opcode fields, presented from a registered output stage with its own valid/ready.
//  Beyond a plain field splitter, it adds:
//   - a reserved-bit legality check;
//   - a flush input;
//   - a decoded-command counter.
// PARAMETERS
//  REG_BITS   3   bits per register number; each operand field is REG_BITS+1 wide (number + ptr bit)
//  CMD_BITS   4   opcode width, occupies top bits of word
//  RSV_BITS   2   reserved bits directly below opcode; must be zero
//  DEPTH      4   FIFO entries, power of 2, >=2
//  CNT_W      16  decoded-command counter width
//  derived: WORD_W = 4*(REG_BITS+1) + 8 + 2 + RSV_BITS + CMD_BITS (32 at defaults)
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst          in   1          reset, asynchronous, active-high
//  flush        in   1          sync clear of FIFO and output stage
//  in_word      in   WORD_W     raw command word
//  in_valid     in   1          in_word valid
//  in_ready     out  1          FIFO can accept
//  out_valid    out  1          decoded fields valid
//  out_ready    in   1          consumer takes decoded command
//  reg_num_s1/s0/d/cnd  out  REG_BITS each  register numbers
//  is_ptr_s1/s0/d/cnd   out  1 each         pointer (indirect) bits
//  flags_s1/s0/d/cnd    out  2 each         per-operand flags
//  is_cond      out  1          conditional command
//  is_cond_true out  1          execute when condition true
//  cmd_code     out  CMD_BITS   opcode
//  illegal      out  1          reserved bits nonzero in this command
//  dec_count    out  CNT_W      commands handed off (out_valid&out_ready), wraps
// BEHAVIOUR
//  Field layout, F=REG_BITS+1, LSB first:
//   - s1[F-1:0], s0, d, cnd: each num then ptr at MSB of field;
//   - flags s1,s0,d,cnd (2b each) at 4F;
//   - is_cond at 4F+8, is_cond_true at 4F+9;
//   - reserved [4F+10 +: RSV_BITS];
//   - cmd_code top CMD_BITS.
//  Reset (async): FIFO empty, out_valid=0, all decoded outputs 0, illegal=0, dec_count=0. in_ready=1 once rst deasserts.
//  in_ready = (fifo_count < DEPTH); independent of out_ready, no same-cycle pass-through when full.
//  Push when in_valid&in_ready. Write/read pointers log2(DEPTH)+1 bits, wrap modulo 2*DEPTH.
//  Output stage loads from FIFO head when fifo nonempty and (!out_valid | out_ready); pop occurs same edge.
//  Latency: word pushed at edge k into empty block -> out_valid=1 after edge k+1. Sustained 1 word/cycle when out_ready=1.
//  Output hold: while out_valid&!out_ready, all decoded outputs and illegal stay stable.
//  out_valid drops after a handoff edge when the FIFO is empty.
//  Simultaneous push and pop: count unchanged. Push into the full FIFO is impossible (in_ready=0).
//  illegal = |reserved bits, registered with the other fields. Illegal words are still delivered, not dropped.
//  dec_count += 1 on each out_valid&out_ready edge; wraps 2^CNT_W-1 -> 0; unaffected by flush.
//  flush (sync, highest priority after rst): FIFO empty, out_valid=0, fields to 0; a push in the same cycle is discarded.
//  rst mid-stream: all queued words lost immediately, no partial output.
// TESTING
//  1: reset, push 32'hA1E4_9C53 with out_ready=1 -> out_valid after 1 edge; s1=3, s0=5, d=4, ptr_d=1, cnd=1, ptr_cnd=1, flags s1/s0/d/cnd=0/1/2/3, is_cond=1, is_cond_true=0, cmd_code=4'hA, illegal=0, dec_count=1.
//  2: push 32'hA500_0000 -> illegal=1, is_cond=1, cmd_code=4'hA, still delivered.
//  3: out_ready=0, push 6 words -> in_ready low after 5 accepted (4 FIFO + output stage). Release out_ready -> words emerge in order, one per cycle, no loss or duplicate.
//  4: alternate in_valid/out_ready randomly for 1000 words vs scoreboard -> exact order, dec_count=1000 mod 2^16.
//  5: flush with 3 queued and in_valid=1 same cycle -> out_valid=0, in_ready=1 next cycle, flushed word never appears.
//  6: assert rst async mid-burst (off clock edge) -> outputs 0 immediately. Preload dec_count near 16'hFFFF via traffic -> wraps to 0.

Source files
------------

// File: rtl/cmd_decode_queue.sv
// cmd_decode_queue: buffered command-word decoder with a DEPTH-entry FIFO and a registered output stage.
//   clk, rst (async, active-high), flush (sync clear of FIFO and output stage)
//   in_word/in_valid/in_ready     : raw command stream into the FIFO
//   out_valid/out_ready           : handshake of the registered decoded command
//   reg_num_*, is_ptr_*, flags_*  : operand fields for s1, s0, d, cnd
//   is_cond, is_cond_true, cmd_code, illegal (reserved bits nonzero)
//   dec_count                     : wrapping count of handed-off commands
module cmd_decode_queue #(
    parameter int REG_BITS = 3,
    parameter int CMD_BITS = 4,
    parameter int RSV_BITS = 2,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16,
    localparam int F       = REG_BITS + 1,
    localparam int WORD_W  = 4*F + 10 + RSV_BITS + CMD_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [WORD_W-1:0]   in_word,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REG_BITS-1:0] reg_num_s1,
    output logic [REG_BITS-1:0] reg_num_s0,
    output logic [REG_BITS-1:0] reg_num_d,
    output logic [REG_BITS-1:0] reg_num_cnd,
    output logic                is_ptr_s1,
    output logic                is_ptr_s0,
    output logic                is_ptr_d,
    output logic                is_ptr_cnd,
    output logic [1:0]          flags_s1,
    output logic [1:0]          flags_s0,
    output logic [1:0]          flags_d,
    output logic [1:0]          flags_cnd,
    output logic                is_cond,
    output logic                is_cond_true,
    output logic [CMD_BITS-1:0] cmd_code,
    output logic                illegal,
    output logic [CNT_W-1:0]    dec_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wp, rp;
    logic [WORD_W-1:0] head;
    logic              empty, full, push, load;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = wp == rp;
    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && in_ready && !flush;
    assign load     = !empty && (!out_valid || out_ready);

    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= in_word;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            out_valid <= 1'b0;
            head      <= '0;
        end else if (flush) begin
            wp        <= '0;
            rp        <= '0;
            out_valid <= 1'b0;
            head      <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (load) begin
                rp        <= rp + 1'b1;
                head      <= mem[rp[AW-1:0]];
                out_valid <= 1'b1;
            end else if (out_ready) out_valid <= 1'b0;
        end

    // Handoffs are counted even in a flush cycle; flush never clears the count.
    always_ff @(posedge clk or posedge rst)
        if (rst) dec_count <= '0;
        else if (out_valid && out_ready) dec_count <= dec_count + 1'b1;

    // Fields are sliced straight out of the registered head word, so they
    // are held for as long as the output stage is stalled.
    assign reg_num_s1   = head[0*F +: REG_BITS];
    assign is_ptr_s1    = head[0*F + REG_BITS];
    assign reg_num_s0   = head[1*F +: REG_BITS];
    assign is_ptr_s0    = head[1*F + REG_BITS];
    assign reg_num_d    = head[2*F +: REG_BITS];
    assign is_ptr_d     = head[2*F + REG_BITS];
    assign reg_num_cnd  = head[3*F +: REG_BITS];
    assign is_ptr_cnd   = head[3*F + REG_BITS];
    assign flags_s1     = head[4*F + 0 +: 2];
    assign flags_s0     = head[4*F + 2 +: 2];
    assign flags_d      = head[4*F + 4 +: 2];
    assign flags_cnd    = head[4*F + 6 +: 2];
    assign is_cond      = head[4*F + 8];
    assign is_cond_true = head[4*F + 9];
    assign illegal      = |head[4*F + 10 +: RSV_BITS];
    assign cmd_code     = head[WORD_W-1 -: CMD_BITS];
endmodule

// File: tb/tb_cmd_decode_queue.sv
// tb_cmd_decode_queue: table vectors plus scoreboard-checked streams for cmd_decode_queue.
module tb_cmd_decode_queue;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_word;
    logic [2:0]  reg_num_s1, reg_num_s0, reg_num_d, reg_num_cnd;
    logic        is_ptr_s1, is_ptr_s0, is_ptr_d, is_ptr_cnd;
    logic [1:0]  flags_s1, flags_s0, flags_d, flags_cnd;
    logic        is_cond, is_cond_true, illegal;
    logic [3:0]  cmd_code;
    logic [15:0] dec_count;

    cmd_decode_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_num_s1(reg_num_s1), .reg_num_s0(reg_num_s0), .reg_num_d(reg_num_d), .reg_num_cnd(reg_num_cnd),
        .is_ptr_s1(is_ptr_s1), .is_ptr_s0(is_ptr_s0), .is_ptr_d(is_ptr_d), .is_ptr_cnd(is_ptr_cnd),
        .flags_s1(flags_s1), .flags_s0(flags_s0), .flags_d(flags_d), .flags_cnd(flags_cnd),
        .is_cond(is_cond), .is_cond_true(is_cond_true), .cmd_code(cmd_code),
        .illegal(illegal), .dec_count(dec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [2:0]  s1, s0, d, cnd;
        logic [3:0]  ptr;
        logic [7:0]  fl;
        logic        c, ct;
        logic [3:0]  cmd;
        logic        ill;
    } vec_t;

    int          checks = 0, errors = 0;
    int          n_hand = 0, cnt_model = 0;
    logic        pushed;
    logic [31:0] q[$];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    function automatic logic [30:0] model(input logic [31:0] w);
        return {w[2:0], w[6:4], w[10:8], w[14:12], w[3], w[7], w[11], w[15],
                w[17:16], w[19:18], w[21:20], w[23:22], w[24], w[25], w[31:28], |w[27:26]};
    endfunction

    function automatic logic [30:0] pack_out();
        return {reg_num_s1, reg_num_s0, reg_num_d, reg_num_cnd, is_ptr_s1, is_ptr_s0, is_ptr_d, is_ptr_cnd,
                flags_s1, flags_s0, flags_d, flags_cnd, is_cond, is_cond_true, cmd_code, illegal};
    endfunction

    // One clock cycle, starting and ending at a falling edge.
    task automatic cycle(input logic v, input logic [31:0] w, input logic r, input logic f);
        in_valid = v; in_word = w; out_ready = r; flush = f;
        #1;
        if (out_valid && out_ready) begin
            n_hand++;
            cnt_model++;
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_output got %0h want none", pack_out());
            end else chk("order", 64'(pack_out()), 64'(model(q.pop_front())));
        end
        pushed = !f && in_valid && in_ready;
        if (f) q.delete();
        else if (pushed) q.push_back(w);
        @(negedge clk);
    endtask

    initial begin
        vec_t        tbl[7];
        logic [30:0] snap;
        int          acc, sent, h0, c0, k;
        tbl[0] = '{32'hA1E4_9C53, 3'd3, 3'd5, 3'd4, 3'd1, 4'b0011, 8'h1B, 1'b1, 1'b0, 4'hA, 1'b0};
        tbl[1] = '{32'hA500_0000, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 8'h00, 1'b1, 1'b0, 4'hA, 1'b1};
        tbl[2] = '{32'hFFFF_FFFF, 3'd7, 3'd7, 3'd7, 3'd7, 4'b1111, 8'hFF, 1'b1, 1'b1, 4'hF, 1'b1};
        tbl[3] = '{32'h0000_0000, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[4] = '{32'h3200_8888, 3'd0, 3'd0, 3'd0, 3'd0, 4'b1111, 8'h00, 1'b0, 1'b1, 4'h3, 1'b0};
        tbl[5] = '{32'h5800_0000, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 8'h00, 1'b0, 1'b0, 4'h5, 1'b1};
        tbl[6] = '{32'h12D8_6E17, 3'd7, 3'd1, 3'd6, 3'd6, 4'b0010, 8'h27, 1'b0, 1'b1, 4'h1, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fields", 64'(pack_out()), 64'd0);
        chk("rst_dec_count", 64'(dec_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Table vectors: latency, field decode and counter per word.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, tbl[i].w, 1'b1, 1'b0);
            chk("lat_edge_k", 64'(out_valid), 64'd0);
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            chk("lat_edge_k1", 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d", i), 64'(pack_out()),
                64'({tbl[i].s1, tbl[i].s0, tbl[i].d, tbl[i].cnd, tbl[i].ptr, tbl[i].fl,
                     tbl[i].c, tbl[i].ct, tbl[i].cmd, tbl[i].ill}));
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            chk("vec_dec_count", 64'(dec_count), 64'(i + 1));
            chk("vec_drop", 64'(out_valid), 64'd0);
        end

        // Back-pressure: 4 FIFO entries plus the output stage, then an ordered drain.
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 32'h1000_0000 + acc, 1'b0, 1'b0);
            if (pushed) acc++;
        end
        chk("bp_accepted", 64'(acc), 64'd5);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        snap = pack_out();
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("bp_hold", 64'(pack_out()), 64'(snap));
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        h0 = n_hand; k = 0;
        while (q.size() != 0 && k < 20) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            k++;
        end
        chk("bp_drain_cycles", 64'(k), 64'd5);
        chk("bp_drain_count", 64'(n_hand - h0), 64'd5);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Random traffic against the scoreboard.
        sent = 0; c0 = cnt_model; h0 = n_hand;
        for (int i = 0; i < 20000 && !(sent == 1000 && q.size() == 0); i++) begin
            cycle(sent < 1000 && $urandom_range(1) == 1, $urandom, $urandom_range(1) == 1, 1'b0);
            if (pushed) sent++;
        end
        chk("rand_sent", 64'(sent), 64'd1000);
        chk("rand_handoffs", 64'(n_hand - h0), 64'd1000);
        chk("rand_dec_count", 64'(dec_count), 64'((c0 + 1000) % 65536));
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with queued words and a simultaneous push.
        cycle(1'b1, 32'h2000_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h2000_0002, 1'b0, 1'b0);
        cycle(1'b1, 32'h2000_0003, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_fields", 64'(pack_out()), 64'd0);
        h0 = n_hand;
        cycle(1'b1, 32'h3300_1234, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_after", 64'(n_hand - h0), 64'd1);

        // Async reset off the clock edge in the middle of a burst.
        cycle(1'b1, 32'h4000_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h4000_0002, 1'b0, 1'b0);
        cycle(1'b1, 32'h4000_0003, 1'b0, 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_fields", 64'(pack_out()), 64'd0);
        chk("async_dec_count", 64'(dec_count), 64'd0);
        @(negedge clk);
        rst = 1'b0; q.delete(); cnt_model = 0;
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_rst_idle", 64'(n_hand - h0), 64'd1);

        // Counter wrap after 65535 streamed commands.
        in_valid = 1'b1; in_word = 32'h0; out_ready = 1'b1; flush = 1'b0;
        repeat (65535) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrap_ffff", 64'(dec_count), 64'hFFFF);
        chk("wrap_idle", 64'(out_valid), 64'd0);
        cycle(1'b1, 32'h5000_0042, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap_zero", 64'(dec_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
